// File: rtl/rsa_modulus_gen.sv
// RSA modulus stage: captures primes p, q from prime_feed and computes n = p*q and
// phi = (p-1)*(q-1) with two lockstep radix-2 shift-add multipliers.
`timescale 1ns/1ps

module rsa_modulus_gen #(
  parameter int WIDTH = 512
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 pqrs_ready,
  input  logic [WIDTH-1:0]     p,
  input  logic [WIDTH-1:0]     q,
  output logic                 next,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   n,
  output logic [2*WIDTH-1:0]   phi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Decrement wraps modulo 2^WIDTH, so p = 0 yields all ones.
  function automatic logic [WIDTH-1:0] dec_mod(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  // One shift-add step: conditionally accumulate the multiplicand.
  function automatic logic [2*WIDTH-1:0] acc_step(
    input logic [2*WIDTH-1:0] acc,
    input logic [2*WIDTH-1:0] mcand,
    input logic               bit0
  );
    return bit0 ? (acc + mcand) : acc;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 capture_s;
  logic                 step_s;

  logic [2*WIDTH-1:0]   mcand_n_r;
  logic [2*WIDTH-1:0]   mcand_phi_r;
  logic [WIDTH-1:0]     mplier_n_r;
  logic [WIDTH-1:0]     mplier_phi_r;
  logic [2*WIDTH-1:0]   acc_n_r;
  logic [2*WIDTH-1:0]   acc_phi_r;
  logic [CW-1:0]        cnt_r;
  logic                 next_r;
  logic                 busy_r;
  logic                 out_valid_r;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pqrs_ready) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        step_s = 1'b1;
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Both multipliers share the counter and advance on the same edges.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mcand_n_r    <= '0;
      mcand_phi_r  <= '0;
      mplier_n_r   <= '0;
      mplier_phi_r <= '0;
      acc_n_r      <= '0;
      acc_phi_r    <= '0;
      cnt_r        <= '0;
    end else if (capture_s) begin
      mcand_n_r    <= {{WIDTH{1'b0}}, p};
      mcand_phi_r  <= {{WIDTH{1'b0}}, dec_mod(p)};
      mplier_n_r   <= q;
      mplier_phi_r <= dec_mod(q);
      acc_n_r      <= '0;
      acc_phi_r    <= '0;
      cnt_r        <= '0;
    end else if (step_s) begin
      acc_n_r      <= acc_step(acc_n_r, mcand_n_r, mplier_n_r[0]);
      acc_phi_r    <= acc_step(acc_phi_r, mcand_phi_r, mplier_phi_r[0]);
      mcand_n_r    <= {mcand_n_r[2*WIDTH-2:0], 1'b0};
      mcand_phi_r  <= {mcand_phi_r[2*WIDTH-2:0], 1'b0};
      mplier_n_r   <= {1'b0, mplier_n_r[WIDTH-1:1]};
      mplier_phi_r <= {1'b0, mplier_phi_r[WIDTH-1:1]};
      cnt_r        <= cnt_r + CW'(1);
    end else begin
      mcand_n_r    <= mcand_n_r;
      mcand_phi_r  <= mcand_phi_r;
      mplier_n_r   <= mplier_n_r;
      mplier_phi_r <= mplier_phi_r;
      acc_n_r      <= acc_n_r;
      acc_phi_r    <= acc_phi_r;
      cnt_r        <= cnt_r;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      next_r      <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      next_r      <= capture_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign next      = next_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign n         = acc_n_r;
  assign phi       = acc_phi_r;

endmodule
